// File: rtl/motor_pwm_ramp_driver_if.sv
// Command bus from the drive-command logic: one strobe capturing a target
// direction and duty for each of the two motor channels.
interface motor_pwm_ramp_driver_if #(
  parameter int DUTY_W = 8
);
  logic              cmd_valid;
  logic              cmd_dir_l;
  logic [DUTY_W-1:0] cmd_duty_l;
  logic              cmd_dir_r;
  logic [DUTY_W-1:0] cmd_duty_r;

  modport master (
    output cmd_valid, cmd_dir_l, cmd_duty_l, cmd_dir_r, cmd_duty_r
  );

  modport slave (
    input cmd_valid, cmd_dir_l, cmd_duty_l, cmd_dir_r, cmd_duty_r
  );
endinterface

// File: rtl/motor_pwm_ramp_driver.sv
// Dual-channel motor PWM driver with slew-limited duty ramps and safe
// direction reversal (decelerate, dead time, flip DIR, accelerate).
module motor_pwm_ramp_driver #(
  parameter int PERIOD       = 100,
  parameter int DUTY_W       = 8,
  parameter int STEP         = 10,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  motor_pwm_ramp_driver_if.slave cmd,
  output logic                   PWML,
  output logic                   PWMR,
  output logic                   DIRL,
  output logic                   DIRR,
  output logic                   nSLPL,
  output logic                   nSLPR,
  output logic                   settled
);
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DC_W  = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam int W1    = DUTY_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'(DEAD_PERIODS - 1);
  localparam logic [W1-1:0]     PERIOD_W  = W1'(PERIOD);
  localparam logic [W1-1:0]     STEP_W    = W1'(STEP);
  localparam logic [DUTY_W-1:0] PERIOD_N  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] STEP_N    = DUTY_W'(STEP);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DECEL = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;
  logic [1:0]       pwm_ch;
  logic [1:0]       dir_ch;
  logic [1:0]       nslp_ch;
  logic [1:0]       ok_ch;
  logic             settled_reg;

  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [DUTY_W-1:0] cur_reg, cur_next;
    logic [DUTY_W-1:0] tgt_reg, tgt_next;
    logic              tgt_dir_reg, tgt_dir_next;
    logic              dir_reg, dir_next;
    logic [1:0]        state_reg, state_next;
    logic [DC_W-1:0]   dead_cnt_reg, dead_cnt_next;
    logic              pwm_reg;
    logic              nslp_reg;
    logic              dir_in;
    logic [DUTY_W-1:0] duty_in;
    logic [W1-1:0]     up_w;
    logic [DUTY_W-1:0] dn_n;

    assign dir_in  = (gi == 0) ? cmd.cmd_dir_l  : cmd.cmd_dir_r;
    assign duty_in = (gi == 0) ? cmd.cmd_duty_l : cmd.cmd_duty_r;

    // Ramp candidates: the upward sum is widened so it cannot wrap past the
    // target, the downward difference saturates at zero.
    assign up_w = W1'(cur_reg) + STEP_W;
    assign dn_n = (W1'(cur_reg) > STEP_W) ? (cur_reg - STEP_N) : '0;

    always_comb begin
      cur_next      = cur_reg;
      tgt_next      = tgt_reg;
      tgt_dir_next  = tgt_dir_reg;
      dir_next      = dir_reg;
      state_next    = state_reg;
      dead_cnt_next = dead_cnt_reg;

      if (cmd.cmd_valid) begin
        tgt_next     = (W1'(duty_in) > PERIOD_W) ? PERIOD_N : duty_in;
        tgt_dir_next = dir_in;
      end

      if (!enable) begin
        cur_next   = '0;
        state_next = ST_RUN;
      end else if (tick) begin
        case (state_reg)
          ST_RUN: begin
            if (tgt_dir_reg != dir_reg) begin
              state_next = ST_DECEL;
            end else if (cur_reg < tgt_reg) begin
              cur_next = (up_w < W1'(tgt_reg)) ? (cur_reg + STEP_N) : tgt_reg;
            end else if (cur_reg > tgt_reg) begin
              cur_next = (dn_n > tgt_reg) ? dn_n : tgt_reg;
            end
          end
          ST_DECEL: begin
            if (tgt_dir_reg == dir_reg) begin
              state_next = ST_RUN;
            end else if (cur_reg == '0) begin
              state_next    = ST_DEAD;
              dead_cnt_next = '0;
            end else begin
              cur_next = dn_n;
            end
          end
          ST_DEAD: begin
            // DIR only flips here, after whole periods of guaranteed-low PWM.
            if (dead_cnt_reg == DEAD_LAST) begin
              dir_next   = tgt_dir_reg;
              state_next = ST_RUN;
            end else begin
              dead_cnt_next = dead_cnt_reg + DC_W'(1);
            end
          end
          default: state_next = ST_RUN;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cur_reg      <= '0;
        tgt_reg      <= '0;
        tgt_dir_reg  <= 1'b0;
        dir_reg      <= 1'b0;
        state_reg    <= ST_RUN;
        dead_cnt_reg <= '0;
        pwm_reg      <= 1'b0;
        nslp_reg     <= 1'b0;
      end else begin
        cur_reg      <= cur_next;
        tgt_reg      <= tgt_next;
        tgt_dir_reg  <= tgt_dir_next;
        dir_reg      <= dir_next;
        state_reg    <= state_next;
        dead_cnt_reg <= dead_cnt_next;
        pwm_reg      <= enable && (state_reg != ST_DEAD) && (DUTY_W'(cnt_reg) < cur_reg);
        nslp_reg     <= enable;
      end
    end

    assign pwm_ch[gi]  = pwm_reg;
    assign dir_ch[gi]  = dir_reg;
    assign nslp_ch[gi] = nslp_reg;
    assign ok_ch[gi]   = (state_reg == ST_RUN) && (cur_reg == tgt_reg) &&
                         (dir_reg == tgt_dir_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settled_reg <= 1'b1;
    end else begin
      settled_reg <= &ok_ch;
    end
  end

  assign PWML    = pwm_ch[0];
  assign PWMR    = pwm_ch[1];
  assign DIRL    = dir_ch[0];
  assign DIRR    = dir_ch[1];
  assign nSLPL   = nslp_ch[0];
  assign nSLPR   = nslp_ch[1];
  assign settled = settled_reg;
endmodule

// File: doc/motor_pwm_ramp_driver.md
Name: motor_pwm_ramp_driver

Overview:
- Parametrised successor to the fixed 20%-duty dual-motor driver.
- Drives left and right DRV-style motor channels, each with a programmable duty, slew-rate-limited ramping and safe direction reversal: decelerate to 0, dead time, flip DIR, accelerate.
- Sits between the drive-command logic and the motor pins PWML/PWMR, DIRL/DIRR and nSLPL/nSLPR.

Parameters:
- PERIOD, 100, PWM period in clk cycles (>=2).
- DUTY_W, 8, duty width; must hold PERIOD.
- STEP, 10, duty change per PWM period while ramping (>=1).
- DEAD_PERIODS, 2, whole PWM periods held at zero before a DIR flip (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = drivers awake; 0 = sleep.
- cmd_valid  in  1  single-cycle strobe that captures the four cmd_* fields.
- cmd_dir_l  in  1  left target direction (0 fwd, 1 rev).
- cmd_duty_l  in  DUTY_W  left target duty, in clk cycles high per period.
- cmd_dir_r  in  1  right target direction.
- cmd_duty_r  in  DUTY_W  right target duty.
- PWML, PWMR  out  1  PWM outputs, registered.
- DIRL, DIRR  out  1  direction outputs, registered.
- nSLPL, nSLPR  out  1  active-low sleep, registered.
- settled  out  1  both channels at target duty and direction, state RUN.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset values: cnt=0; per channel cur=0, tgt=0, tgt_dir=0, state=RUN, dead_cnt=0. Outputs: PWM=0, DIR=0, nSLP=0, settled=1.

Counter:
- cnt counts 0..PERIOD-1 and wraps to 0.
- tick = (cnt==PERIOD-1).
- cnt is shared by both channels.

Command capture:
- cmd_valid=1 latches tgt_dir, and tgt=min(cmd_duty, PERIOD), on the next edge. This is accepted in any state; there is no ready signal.
- A command that coincides with tick is captured, but the ramp step on that tick uses the old tgt.

Per-channel FSM. All state and cur updates occur only on tick, except enable=0 handling:
- RUN, tgt_dir==DIR:
  - cur<tgt: cur=min(cur+STEP, tgt).
  - cur>tgt: cur=max(cur-STEP, tgt).
  - Arithmetic is done at DUTY_W+1 bits, with no wrap.
- RUN, tgt_dir!=DIR: go to DECEL.
- DECEL:
  - cur=max(cur-STEP, 0).
  - If cur is already 0: go to DEAD, dead_cnt=0.
  - If tgt_dir returns to equal DIR: go back to RUN and ramp from the current cur.
- DEAD:
  - PWM is held 0.
  - dead_cnt increments per tick.
  - When dead_cnt==DEAD_PERIODS-1 on a tick: DIR<=tgt_dir, go to RUN.
  - A tgt_dir change while in DEAD is honoured at exit, not earlier.

PWM generation:
- PWM <= enable && state!=DEAD && (cnt < cur).
- One clk of latency from cnt to the pin.
- A new cur takes effect from cnt=0 of the next period.
- cur==PERIOD gives a constant high; cur==0 gives a constant low.

Sleep:
- nSLP <= enable.
- enable=0 forces, on the next edge: cur=0, state=RUN, PWM=0.
- DIR and tgt are kept.
- On re-enable, the channel ramps from 0. If tgt_dir!=DIR, the FSM goes via DECEL (immediately 0) and then DEAD.

settled:
- Registered.
- 1 when, for both channels, state==RUN, cur==tgt and DIR==tgt_dir.

rst mid-ramp or mid-DEAD:
- Returns everything to the reset values on the next edge.

Test Plan:
- Reset: hold rst 3 cycles with enable=1 -> all outputs at reset values; after release, nSLPL=nSLPR=1 one cycle later and PWM stays 0.
- Forward ramp (PERIOD=100, STEP=10): cmd duty_l=50, dir_l=0 -> PWML high 10,20,30,40,50 cycles in successive periods, then steady 50; settled rises after cur reaches 50.
- Clip and saturate: cmd duty_r=255 -> tgt=100; PWMR constant high once ramped; STEP=30 sequence 30,60,90,100.
- Reversal: steady 30 fwd, cmd dir_l=1 duty 30 -> duty 20,10,0, then 2 zero periods, then DIRL=1 and ramp 10,20,30; DIRL never toggles while PWML could be high.
- Abort reversal: during DECEL at cur=20, re-command dir=0 -> back to RUN, ramps up from 20; DIRL never changes.
- Sleep mid-ramp: enable=0 at cur=40 -> next edge PWML=0, nSLPL=0; re-enable -> ramp restarts at 10; rst asserted during DEAD -> DIR=0, cur=0.
